// File: rtl/pci_reset_sequencer_pkg.sv
// Shared types and defaults for the PCI reset sequencer and its synchronizer.
// State encodings are fixed because other pci_clk blocks decode them.
package pci_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    RST_DRIVE   = 2'b00,
    RST_RELEASE = 2'b01,
    RST_RUN     = 2'b10
  } rst_state_e;

  localparam int unsigned TRST_CYCLES_DEFAULT     = 33000;
  localparam int unsigned CNT_WIDTH_DEFAULT       = 16;
  localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
  localparam int unsigned RECOVERY_CYCLES_DEFAULT = 8;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pci_reset_synchronizer.sv
// Async-set, sync-clear flop chain; releases its output STAGES clocks after
// async_set drops. STAGES must be at least 2.
module pci_reset_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic async_set,
  output logic sync_out
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge async_set) begin
    if (async_set) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/pci_reset_sequencer.sv
// PCI reset sequencer: cleans up the raw pad reset for pci_clk logic and, in
// host mode, times the RST# pulse driven through the pad output enable.
//
// state       | meaning
// RST_DRIVE   | host: drive RST# for TRST_CYCLES; device: leave next cycle
// RST_RELEASE | wait for the synchronized pad reset to clear (no timeout)
// RST_RUN     | count recovery, then release pci_reset_sync and run
module pci_reset_sequencer
  import pci_reset_sequencer_pkg::*;
#(
  parameter int unsigned TRST_CYCLES     = TRST_CYCLES_DEFAULT,
  parameter int unsigned CNT_WIDTH       = CNT_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int unsigned RECOVERY_CYCLES = RECOVERY_CYCLES_DEFAULT
) (
  input  logic pci_clk,
  input  logic pci_reset_l,
  input  logic pci_host_mode,
  input  logic pci_reset_raw,
  input  logic sw_reset_request,
  output logic pci_reset_out_oe_comb,
  output logic pci_reset_sync,
  output logic pci_bus_running
);

  localparam int unsigned REC_W = cnt_bits(RECOVERY_CYCLES);
  localparam logic [CNT_WIDTH-1:0] TRST_LAST = CNT_WIDTH'(TRST_CYCLES - 1);
  localparam logic [REC_W-1:0]     REC_LAST  = REC_W'(RECOVERY_CYCLES - 1);

  logic sync_set;
  logic sync_raw;

  rst_state_e           state_q, state_d;
  logic                 drive_q, drive_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [REC_W-1:0]     rec_q, rec_d;
  logic                 hold_q, hold_d;
  logic                 running_q, running_d;

  // Chip reset also sets the chain so the release path is identical for both.
  assign sync_set = pci_reset_raw | ~pci_reset_l;

  pci_reset_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_raw_sync (
    .clk       (pci_clk),
    .async_set (sync_set),
    .sync_out  (sync_raw)
  );

  always_comb begin
    state_d   = state_q;
    drive_d   = drive_q;
    cnt_d     = cnt_q;
    rec_d     = rec_q;
    hold_d    = hold_q;
    running_d = running_q;

    case (state_q)
      RST_DRIVE: begin
        // A pulse already under way finishes even if the strap drops.
        if (pci_host_mode || (cnt_q != '0)) begin
          if (cnt_q == TRST_LAST) begin
            drive_d = 1'b0;
            cnt_d   = '0;
            state_d = RST_RELEASE;
          end else begin
            drive_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          drive_d = 1'b0;
          state_d = RST_RELEASE;
        end
      end

      RST_RELEASE: begin
        rec_d = '0;
        if (!sync_raw) begin
          state_d = RST_RUN;
        end
      end

      RST_RUN: begin
        if (sw_reset_request && pci_host_mode) begin
          state_d   = RST_DRIVE;
          drive_d   = 1'b1;
          cnt_d     = '0;
          rec_d     = '0;
          hold_d    = 1'b1;
          running_d = 1'b0;
        end else if (sync_raw) begin
          state_d   = RST_RELEASE;
          rec_d     = '0;
          hold_d    = 1'b1;
          running_d = 1'b0;
        end else if (hold_q) begin
          rec_d = rec_q + 1'b1;
          if (rec_q == REC_LAST) begin
            hold_d    = 1'b0;
            running_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = RST_DRIVE;
        drive_d   = 1'b1;
        cnt_d     = '0;
        rec_d     = '0;
        hold_d    = 1'b1;
        running_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pci_clk or negedge pci_reset_l) begin
    if (!pci_reset_l) begin
      state_q   <= RST_DRIVE;
      drive_q   <= 1'b1;
      cnt_q     <= '0;
      rec_q     <= '0;
      hold_q    <= 1'b1;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drive_q   <= drive_d;
      cnt_q     <= cnt_d;
      rec_q     <= rec_d;
      hold_q    <= hold_d;
      running_q <= running_d;
    end
  end

  assign pci_reset_out_oe_comb = drive_q & pci_host_mode;
  assign pci_reset_sync        = hold_q | sync_raw;
  assign pci_bus_running       = running_q & ~pci_reset_sync;

endmodule

// File: tb/tb_pci_reset_sequencer.sv
// Directed-plus-random bench for pci_reset_sequencer; the pad is modelled as
// raw = (oe delayed 1 ns) OR an external agent's reset.
module tb_pci_reset_sequencer;

  localparam int TRST = 16;
  localparam int REC  = 8;
  localparam int SYNC = 2;

  logic pci_clk = 1'b0;
  logic pci_reset_l;
  logic pci_host_mode;
  logic ext_rst;
  logic sw_reset_request;
  logic oe;
  logic rsync;
  logic running;
  wire  pad_oe_dly;
  wire  pci_reset_raw;

  assign #1 pad_oe_dly   = oe;
  assign pci_reset_raw   = pad_oe_dly | ext_rst;

  always #15 pci_clk = ~pci_clk;

  pci_reset_sequencer #(
    .TRST_CYCLES     (TRST),
    .CNT_WIDTH       (16),
    .SYNC_STAGES     (SYNC),
    .RECOVERY_CYCLES (REC)
  ) dut (
    .pci_clk               (pci_clk),
    .pci_reset_l           (pci_reset_l),
    .pci_host_mode         (pci_host_mode),
    .pci_reset_raw         (pci_reset_raw),
    .sw_reset_request      (sw_reset_request),
    .pci_reset_out_oe_comb (oe),
    .pci_reset_sync        (rsync),
    .pci_bus_running       (running)
  );

  int n_cmp;
  int n_err;
  int r_rise, r_fall, r_hi, r_sfall, r_rrise;

  // Edge index at which the bus is released when the raw reset falls between
  // edge fall_idx and the next: the chain drains in SYNC edges, the FSM needs
  // one more edge to see it clear, then REC recovery edges.
  function automatic int settle(input int fall_idx);
    return fall_idx + SYNC + 1 + REC;
  endfunction

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pci_clk);
    #1;
  endtask

  // Samples once now (index 0) and once after each following edge. Stimulus
  // scheduled at index i is applied after that sample, so edge i+1 sees it.
  task automatic track(input int bound, input int sw_a, input int sw_b,
                       input int ext_on, input int ext_off, input int glitch,
                       output int oe_rise, output int oe_fall, output int oe_hi,
                       output int sync_fall, output int run_rise);
    bit seen_sync = 1'b0;
    bit seen_idle = 1'b0;
    oe_rise = -1; oe_fall = -1; oe_hi = 0; sync_fall = -1; run_rise = -1;
    for (int i = 0; i <= bound; i++) begin
      if (i > 0) tick();
      if (oe === 1'b1) begin
        oe_hi++;
        if (oe_rise < 0) oe_rise = i;
      end else if (oe_rise >= 0 && oe_fall < 0) begin
        oe_fall = i;
      end
      if (rsync === 1'b1) seen_sync = 1'b1;
      else if (seen_sync && sync_fall < 0) sync_fall = i;
      if (running === 1'b0) seen_idle = 1'b1;
      else if (seen_idle && run_rise < 0) run_rise = i;
      if (sync_fall >= 0 && run_rise >= 0) break;
      sw_reset_request = (i == sw_a) || (i == sw_b);
      if (i == ext_on)  ext_rst = 1'b1;
      if (i == ext_off) ext_rst = 1'b0;
      if (i == glitch) begin
        #10 ext_rst = 1'b1;
        #1  check_bit("glitch_sync_async", rsync, 1'b1);
        check_bit("glitch_running_drop", running, 1'b0);
        #2  ext_rst = 1'b0;
      end
    end
    sw_reset_request = 1'b0;
  endtask

  task automatic expect_seq(input string tag, input int e_rise, input int e_fall,
                            input int e_hi, input int e_sync);
    check_int({tag, "_oe_rise"},   r_rise,  e_rise);
    check_int({tag, "_oe_fall"},   r_fall,  e_fall);
    check_int({tag, "_oe_width"},  r_hi,    e_hi);
    check_int({tag, "_sync_fall"}, r_sfall, e_sync);
    check_int({tag, "_run_rise"},  r_rrise, e_sync);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int abort_at;
    int len;
    int g;
    int sw2;
    int bad;
    n_cmp = 0;
    n_err = 0;
    pci_reset_l      = 1'b0;
    pci_host_mode    = 1'b1;
    ext_rst          = 1'b0;
    sw_reset_request = 1'b0;

    repeat (3) tick();
    check_bit("reset_oe_host", oe, 1'b1);
    check_bit("reset_sync", rsync, 1'b1);
    check_bit("reset_running", running, 1'b0);
    pci_host_mode = 1'b0;
    #1 check_bit("reset_oe_device", oe, 1'b0);
    pci_host_mode = 1'b1;
    #1;

    // Host power-on.
    tick();
    pci_reset_l = 1'b1;
    track(200, -1, -1, -1, -1, -1, r_rise, r_fall, r_hi, r_sfall, r_rrise);
    expect_seq("host_poweron", 0, TRST, TRST, settle(TRST));

    // Software reset; a second request at cycle 5 of the pulse is ignored.
    track(200, 0, 5, -1, -1, -1, r_rise, r_fall, r_hi, r_sfall, r_rrise);
    expect_seq("sw_req_ext5", 1, 1 + TRST, TRST, settle(1 + TRST));

    // Second request at a random point in RST_DRIVE or RST_RELEASE.
    sw2 = int'($urandom_range(1, TRST + SYNC));
    track(200, 0, sw2, -1, -1, -1, r_rise, r_fall, r_hi, r_sfall, r_rrise);
    expect_seq("sw_req_rand", 1, 1 + TRST, TRST, settle(1 + TRST));

    // Request and external reset together: the request wins.
    track(200, 0, -1, 0, 3, -1, r_rise, r_fall, r_hi, r_sfall, r_rrise);
    expect_seq("sw_and_raw", 1, 1 + TRST, TRST, settle(1 + TRST));

    // Chip reset in the middle of a host pulse, then a full pulse from zero.
    for (int k = 0; k < 2; k++) begin
      abort_at = (k == 0) ? 7 : int'($urandom_range(1, TRST - 1));
      sw_reset_request = 1'b1;
      tick();
      sw_reset_request = 1'b0;
      repeat (abort_at - 1) tick();
      #10 pci_reset_l = 1'b0;
      #1;
      check_bit("abort_oe", oe, 1'b1);
      check_bit("abort_sync", rsync, 1'b1);
      check_bit("abort_running", running, 1'b0);
      tick();
      tick();
      pci_reset_l = 1'b1;
      track(200, -1, -1, -1, -1, -1, r_rise, r_fall, r_hi, r_sfall, r_rrise);
      expect_seq("abort_restart", 0, TRST, TRST, settle(TRST));
    end

    // Device mode power-on.
    pci_reset_l   = 1'b0;
    pci_host_mode = 1'b0;
    #1;
    check_bit("dev_reset_oe", oe, 1'b0);
    check_bit("dev_reset_sync", rsync, 1'b1);
    check_bit("dev_reset_running", running, 1'b0);
    tick();
    tick();
    pci_reset_l = 1'b1;
    track(200, -1, -1, -1, -1, -1, r_rise, r_fall, r_hi, r_sfall, r_rrise);
    expect_seq("dev_poweron", -1, -1, 0, settle(0));

    // Software requests have no effect in device mode.
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      if (rsync !== 1'b0 || oe !== 1'b0 || running !== 1'b1) bad++;
      sw_reset_request = (i == 0) || (i == 7);
    end
    sw_reset_request = 1'b0;
    check_int("dev_sw_ignored", bad, 0);

    // External RST# pulses while running.
    for (int k = 0; k < 2; k++) begin
      len = (k == 0) ? 40 : int'($urandom_range(5, 60));
      ext_rst = 1'b1;
      #1;
      check_bit("ext_sync_async", rsync, 1'b1);
      check_bit("ext_running_drop", running, 1'b0);
      track(300, -1, -1, -1, len, -1, r_rise, r_fall, r_hi, r_sfall, r_rrise);
      expect_seq("dev_ext_pulse", -1, -1, 0, settle(len));
    end

    // Sub-cycle glitches on the raw reset.
    for (int k = 0; k < 2; k++) begin
      g = int'($urandom_range(0, 3));
      track(200, -1, -1, -1, -1, g, r_rise, r_fall, r_hi, r_sfall, r_rrise);
      expect_seq("dev_glitch", -1, -1, 0, settle(g));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
